// File: rtl/mm_result_unloader.sv
// mm_result_unloader: snapshots the Montgomery multiplier result on the rising
// edge of done and streams it out LSW-first over a valid/ready word bus.
// A done edge that arrives mid-stream is dropped and flagged in a sticky overrun bit.
module mm_result_unloader #(
   parameter  int INPUT_SIZE = 2048,
   parameter  int WORD_SIZE  = 64,
   localparam int NUM_WORDS  = INPUT_SIZE / WORD_SIZE,
   localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  done,
   input  logic [INPUT_SIZE-1:0] result,
   output logic [WORD_SIZE-1:0]  out_bus,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [IDX_W-1:0]      word_idx,
   output logic                  busy,
   output logic                  overrun,
   input  logic                  clr_overrun
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t                               state, state_nxt;
   logic [NUM_WORDS-1:0][WORD_SIZE-1:0]  shadow;
   logic [IDX_W-1:0]                     idx_nxt;
   logic                                 done_d, done_rise, at_last, xfer;
   logic                                 load, ovr_set;

   assign done_rise = done & ~done_d;
   assign at_last   = (word_idx == LAST_IDX);
   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign xfer      = out_valid & out_ready;
   assign out_last  = out_valid & at_last;
   // Gate with valid so the bus reads zero while idle and during reset.
   assign out_bus   = out_valid ? shadow[word_idx] : '0;

   // Next state, word index, snapshot load and overrun detection.
   always_comb begin
      state_nxt = state;
      idx_nxt   = word_idx;
      load      = 1'b0;
      ovr_set   = 1'b0;
      case (state)
         IDLE: begin
            if (done_rise) begin
               load      = 1'b1;
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (xfer && at_last) begin
               idx_nxt = '0;
               // A new result on the final transfer edge chains straight on.
               if (done_rise) load = 1'b1;
               else           state_nxt = IDLE;
            end else begin
               if (xfer)      idx_nxt = word_idx + 1'b1;
               if (done_rise) ovr_set = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, index, snapshot, edge-detect and sticky overrun registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         word_idx <= '0;
         shadow   <= '0;
         done_d   <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         word_idx <= idx_nxt;
         done_d   <= done;
         if (load) shadow <= result;
         // A fresh overrun beats a simultaneous clear.
         overrun  <= ovr_set | (overrun & ~clr_overrun);
      end
   end

endmodule

// File: tb/tb_mm_result_unloader.sv
// Scoreboard bench for mm_result_unloader: stimulus pushes expected words,
// a negedge monitor pops and compares every transfer.
module tb_mm_result_unloader;

   localparam int INPUT_SIZE = 2048;
   localparam int WORD_SIZE  = 64;
   localparam int NUM_WORDS  = INPUT_SIZE / WORD_SIZE;
   localparam int IDX_W      = $clog2(NUM_WORDS);
   localparam logic [63:0] B1 = 64'h1000_0000_0000_0000;
   localparam logic [63:0] B2 = 64'hDEAD_BEEF_0000_0000;

   typedef struct {
      logic [63:0] data;
      int          idx;
      bit          last;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  done;
   logic [INPUT_SIZE-1:0] result;
   logic [WORD_SIZE-1:0]  out_bus;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic [IDX_W-1:0]      word_idx;
   logic                  busy;
   logic                  overrun;
   logic                  clr_overrun;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   mm_result_unloader #(.INPUT_SIZE(INPUT_SIZE), .WORD_SIZE(WORD_SIZE)) dut (
      .clk(clk), .reset(reset), .done(done), .result(result),
      .out_bus(out_bus), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .word_idx(word_idx), .busy(busy),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [INPUT_SIZE-1:0] mk(input logic [63:0] base);
      logic [INPUT_SIZE-1:0] r;
      for (int k = 0; k < NUM_WORDS; k++) r[k*WORD_SIZE +: WORD_SIZE] = base + 64'(k);
      return r;
   endfunction

   task automatic push_exp(input logic [63:0] base);
      for (int k = 0; k < NUM_WORDS; k++) q.push_back('{base + 64'(k), k, k == NUM_WORDS-1});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse done for one cycle with a new result; returns with the first word visible.
   task automatic start(input logic [63:0] base);
      done   = 1'b1;
      result = mk(base);
      push_exp(base);
      tick();
      done   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int cycles);
      cycles = 0;
      while (busy && cycles < budget) begin
         tick();
         cycles++;
      end
      if (busy) check("wait_idle_timeout", 64'd1, 64'd0);
   endtask

   // Monitor: compare each transfer against the scoreboard, and check stall stability.
   logic                 stall_pend = 1'b0;
   logic [WORD_SIZE-1:0] prev_bus;
   logic [IDX_W-1:0]     prev_idx;
   always @(negedge clk) begin
      exp_t e;
      if (reset && out_valid) begin
         if (stall_pend) begin
            check("stall_bus_stable", out_bus, prev_bus);
            check("stall_idx_stable", 64'(word_idx), 64'(prev_idx));
         end
         if (out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_transfer", 64'(word_idx), 64'hFFFF);
            end else begin
               e = q.pop_front();
               check("mon_data", out_bus, e.data);
               check("mon_idx", 64'(word_idx), 64'(e.idx));
               check("mon_last", 64'(out_last), 64'(e.last));
            end
            stall_pend = 1'b0;
         end else begin
            stall_pend = 1'b1;
            prev_bus   = out_bus;
            prev_idx   = word_idx;
         end
      end else begin
         stall_pend = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, stalls;
      reset = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0; clr_overrun = 1'b0;
      repeat (2) tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_idx", 64'(word_idx), 64'd0);
      check("rst_bus", out_bus, 64'd0);
      reset = 1'b1;
      repeat (2) tick();

      // Basic unload with ready always high.
      out_ready = 1'b1;
      start(B1);
      check("t1_valid_latency", 64'(out_valid), 64'd1);
      check("t1_first_bus", out_bus, B1);
      repeat (31) tick();
      check("t1_busy_w31", 64'(busy), 64'd1);
      check("t1_last_w31", 64'(out_last), 64'd1);
      tick();
      check("t1_busy_fall", 64'(busy), 64'd0);
      check("t1_q_empty", 64'(q.size()), 64'd0);
      repeat (2) tick();

      // Backpressure: ready pattern 1,0,0 per cycle.
      start(B1);
      cyc = 0; stalls = 0;
      while (busy && cyc < 300) begin
         out_ready = (cyc % 3 == 0);
         if (!out_ready) stalls++;
         tick();
         cyc++;
      end
      check("t2_cycles", 64'(cyc), 64'd94);
      check("t2_stalls", 64'(stalls), 64'd62);
      check("t2_q_empty", 64'(q.size()), 64'd0);
      out_ready = 1'b1;
      repeat (2) tick();

      // Overrun: second done at word 10 is dropped.
      start(B1);
      repeat (10) tick();
      check("t3_idx10", 64'(word_idx), 64'd10);
      done = 1'b1; result = '1;
      tick();
      done = 1'b0;
      check("t3_overrun_set", 64'(overrun), 64'd1);
      check("t3_idx11", 64'(word_idx), 64'd11);
      wait_idle(100, cyc);
      check("t3_tail_cycles", 64'(cyc), 64'd21);
      check("t3_overrun_sticky", 64'(overrun), 64'd1);
      check("t3_q_empty", 64'(q.size()), 64'd0);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check("t3_overrun_clr", 64'(overrun), 64'd0);
      repeat (2) tick();

      // Back-to-back: new done on the final-word transfer edge.
      start(B1);
      repeat (31) tick();
      check("t4_idx31", 64'(word_idx), 64'd31);
      done = 1'b1; result = mk(B2); push_exp(B2);
      tick();
      done = 1'b0;
      check("t4_valid", 64'(out_valid), 64'd1);
      check("t4_idx0", 64'(word_idx), 64'd0);
      check("t4_bus", out_bus, B2);
      check("t4_no_overrun", 64'(overrun), 64'd0);
      wait_idle(100, cyc);
      check("t4_cycles", 64'(cyc), 64'd32);
      check("t4_q_empty", 64'(q.size()), 64'd0);
      repeat (2) tick();

      // Asynchronous reset mid-stream.
      start(B1);
      repeat (17) tick();
      check("t5_idx17", 64'(word_idx), 64'd17);
      #2 reset = 1'b0;
      #1;
      check("t5_async_valid", 64'(out_valid), 64'd0);
      check("t5_async_busy", 64'(busy), 64'd0);
      check("t5_async_idx", 64'(word_idx), 64'd0);
      check("t5_async_bus", out_bus, 64'd0);
      check("t5_async_last", 64'(out_last), 64'd0);
      q.delete();
      tick();
      reset = 1'b1;
      tick();
      check("t5_no_resume", 64'(out_valid), 64'd0);
      start(B2);
      check("t5_new_idx", 64'(word_idx), 64'd0);
      check("t5_new_bus", out_bus, B2);
      wait_idle(100, cyc);
      check("t5_q_empty", 64'(q.size()), 64'd0);
      repeat (2) tick();

      // Held done: one stream only, no overrun.
      done = 1'b1; result = mk(B1); push_exp(B1);
      tick();
      result = '1;
      repeat (99) tick();
      done = 1'b0;
      repeat (5) tick();
      check("t6_idle", 64'(busy), 64'd0);
      check("t6_no_overrun", 64'(overrun), 64'd0);
      check("t6_q_empty", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mm_result_unloader.md
Name: mm_result_unloader

Overview:
- Output-side counterpart of the 64-bit operand-load bus on the 2048-bit Montgomery multiplier.
- When the multiplier asserts done, the block snapshots its INPUT_SIZE-bit Result into a shadow register.
- It then streams the snapshot out as NUM_WORDS words of WORD_SIZE bits over a valid/ready bus, least-significant word first, in the same word order the operand bus uses for loading.
- It decouples the multiplier from a slow downstream consumer and flags results that were lost.

Parameters:
- INPUT_SIZE, 2048, operand/result width in bits.
- WORD_SIZE, 64, bus word width in bits; INPUT_SIZE must be an integer multiple of WORD_SIZE.
- NUM_WORDS, INPUT_SIZE/WORD_SIZE (32), words per result; derived, not overridden.
- IDX_W, clog2(NUM_WORDS) (5), word index width; derived.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- done  input  1  multiplier completion level; the block acts on its rising edge.
- result  input  INPUT_SIZE  multiplier Result; sampled only on the done rising edge.
- out_bus  output  WORD_SIZE  current result word.
- out_valid  output  1  out_bus holds a valid word.
- out_ready  input  1  consumer accepts the word; a transfer occurs on a clk edge with out_valid=1 and out_ready=1.
- out_last  output  1  high with out_valid on word NUM_WORDS-1.
- word_idx  output  IDX_W  index of the word on out_bus.
- busy  output  1  a snapshot is held and not yet fully transferred.
- overrun  output  1  sticky: a result arrived while busy and was dropped.
- clr_overrun  input  1  synchronous clear for overrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - out_valid, out_last, busy and overrun go to 0; word_idx goes to 0; out_bus goes to 0.
  - The shadow register and the done edge-detect register (done_d) go to 0.
- Edge detect: done_rise = done & ~done_d. done_d is registered every cycle. A done held high produces exactly one done_rise.
- IDLE, on done_rise:
  - Load shadow <= result; word_idx <= 0.
  - Go to SEND; out_valid and busy become 1 on the same edge.
  - out_bus is the combinational or registered view of shadow[WORD_SIZE-1:0]. It must be valid in the cycle out_valid=1.
  - Latency: first word is visible 1 cycle after done_rise is sampled.
- SEND:
  - out_bus = shadow[word_idx*WORD_SIZE +: WORD_SIZE]; out_last = (word_idx == NUM_WORDS-1).
  - On a transfer with word_idx < NUM_WORDS-1: word_idx increments by 1.
  - On a transfer with word_idx = NUM_WORDS-1:
    - If done_rise is present on the same edge: reload shadow, set word_idx to 0, stay in SEND (back-to-back, no bubble, no overrun).
    - Otherwise: word_idx goes to 0, out_valid, out_last and busy go to 0, and the state returns to IDLE.
  - While out_valid=1 and out_ready=0, out_bus, word_idx and out_last hold stable. out_valid is never withdrawn without a transfer.
  - With out_ready held at 1, a full result takes exactly NUM_WORDS cycles.
- Overrun:
  - Trigger: done_rise in SEND, except on the final-word transfer edge.
  - Effect: overrun <= 1; shadow and word_idx are unaffected; the new result is discarded.
  - Clearing: clr_overrun=1 clears overrun, but overrun=1 wins if a new overrun occurs on the same edge.
- word_idx never exceeds NUM_WORDS-1; there is no wrap beyond the last word.
- Reset mid-transfer aborts immediately. No partial result resumes after reset; the next done_rise starts a fresh result at word 0.
- out_ready is ignored in IDLE.

Test Plan:
- Basic unload:
  - Stimulus: result = {32 words, word k = 64'h1000_0000_0000_0000 + k}; pulse done; out_ready=1.
  - Required: 32 consecutive transfers, word k = 0x1000...000k, out_last only on k=31, busy falls the cycle after.
- Backpressure:
  - Stimulus: same result; out_ready toggles 1,0,0,1,...
  - Required: each word appears exactly once, in order; out_bus is stable across stalls; total cycles = 32 + stall count.
- Overrun:
  - Stimulus: done rises again at word 10 with result = all 1s.
  - Required: overrun=1; words 10..31 still come from the first result; IDLE after word 31; clr_overrun=1 then overrun=0.
- Back-to-back:
  - Stimulus: done_rise coincides with the word-31 transfer; second result = 64'hDEAD_BEEF_0000_0000 + k.
  - Required: next cycle out_valid=1, word_idx=0, out_bus=0xDEADBEEF00000000; overrun stays 0.
- Reset mid-stream:
  - Stimulus: reset=0 asynchronously at word 17, released, then done pulses.
  - Required: outputs go to 0 without waiting for clk; the next stream starts at word 0 of the new result.
- Held done:
  - Stimulus: done held high for 100 cycles.
  - Required: exactly one result of 32 words is streamed; no overrun.
